// File: rtl/orion_mem_arbiter.sv
// Two-requester arbiter in front of one single-port memory.
// The instruction fetch port and the data port share the memory with one access in flight.
// The winner is picked combinationally in idle, so a grant costs no extra cycle. Each
// response goes only to the port that owns the access. Per-port completion counters saturate.
module orion_mem_arbiter #(
  parameter int unsigned ADDRW    = 32,
  parameter int unsigned DATAW    = 32,
  parameter int unsigned MASKW    = 4,
  parameter int unsigned ARB_MODE = 0,   // 0: round-robin, 1: fixed priority with D first
  parameter int unsigned CNTW     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // instruction fetch port
  input  logic [ADDRW-1:0] i_addr_i,
  input  logic             i_valid_i,
  output logic [DATAW-1:0] i_rdata_o,
  output logic             i_resp_o,
  // data port
  input  logic [ADDRW-1:0] d_addr_i,
  input  logic [DATAW-1:0] d_wdata_i,
  input  logic [MASKW-1:0] d_mask_i,
  input  logic             d_we_i,
  input  logic             d_valid_i,
  output logic [DATAW-1:0] d_rdata_o,
  output logic             d_resp_o,
  // shared memory port
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [DATAW-1:0] mem_wdata_o,
  output logic [MASKW-1:0] mem_mask_o,
  output logic             mem_we_o,
  output logic             mem_valid_o,
  input  logic [DATAW-1:0] mem_rdata_i,
  input  logic             mem_resp_i,
  // completed-transaction counters
  output logic [CNTW-1:0]  i_grants_o,
  output logic [CNTW-1:0]  d_grants_o
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e          state_q, state_d;
  logic            rr_last_q, rr_last_d;  // 1: D completed last, so I wins the next tie
  logic [CNTW-1:0] i_cnt_q, i_cnt_d;
  logic [CNTW-1:0] d_cnt_q, d_cnt_d;
  logic            grant_i, grant_d;

  // Grant selection: combinational in idle, held by the busy state otherwise.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_valid_i && d_valid_i) begin
          if (ARB_MODE == 1) begin
            grant_d = 1'b1;
          end else if (rr_last_q) begin
            grant_i = 1'b1;
          end else begin
            grant_d = 1'b1;
          end
        end else begin
          grant_i = i_valid_i;
          grant_d = d_valid_i;
        end
      end
      StBusyI: grant_i = 1'b1;
      StBusyD: grant_d = 1'b1;
      default: ;
    endcase
    // While reset is held every output must read zero, even with a request pending.
    if (!rst_ni) begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

  // Memory-side mux and per-port response routing.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_mask_o  = '0;
    mem_we_o    = 1'b0;
    if (grant_i) begin
      mem_addr_o = i_addr_i;
      mem_mask_o = '1;
    end else if (grant_d) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_mask_o  = d_mask_i;
      mem_we_o    = d_we_i;
    end
    mem_valid_o = grant_i | grant_d;
    i_resp_o    = grant_i & mem_resp_i;
    d_resp_o    = grant_d & mem_resp_i;
    i_rdata_o   = mem_rdata_i;
    d_rdata_o   = mem_rdata_i;
  end

  // Next state, round-robin pointer and saturating counters.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    i_cnt_d   = i_cnt_q;
    d_cnt_d   = d_cnt_q;
    if (i_resp_o) begin
      state_d   = StIdle;
      rr_last_d = 1'b0;
      if (i_cnt_q != '1) i_cnt_d = i_cnt_q + CNTW'(1);
    end else if (d_resp_o) begin
      state_d   = StIdle;
      rr_last_d = 1'b1;
      if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNTW'(1);
    end else if (grant_i) begin
      state_d = StBusyI;
    end else if (grant_d) begin
      state_d = StBusyD;
    end
  end

  // State registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      rr_last_q <= 1'b1;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
    end
  end

  assign i_grants_o = i_cnt_q;
  assign d_grants_o = d_cnt_q;

  // Requesters must hold valid until their response.
  assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == StBusyI) |-> i_valid_i);
  assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == StBusyD) |-> d_valid_i);

endmodule

// File: tb/tb_orion_mem_arbiter.sv
// Bench for orion_mem_arbiter: instance 0 is round-robin with 16-bit counters, instance 1 is
// fixed priority with 2-bit counters. Each has its own two-cycle spram model.
module tb_orion_mem_arbiter;

  typedef struct {
    int          inst;
    bit          port;  // 0: I, 1: D
    bit          chk;   // compare read data
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [3:0]  d_mask [2];
  logic        d_we [2];
  logic        i_valid [2];
  logic        d_valid [2];
  logic [31:0] i_rdata [2];
  logic [31:0] d_rdata [2];
  logic        i_resp [2];
  logic        d_resp [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_mask [2];
  logic        mem_we [2];
  logic        mem_valid [2];
  logic [31:0] m_rdata [2];
  logic        m_resp [2];
  logic        extra_resp [2];
  logic        mem_resp [2];
  int          m_cnt [2];
  logic [31:0] mem [2][256];
  logic [31:0] ref_mem [2][256];
  logic [15:0] i_grants0, d_grants0;
  logic [1:0]  i_grants1, d_grants1;
  exp_t        sb[$];
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  assign mem_resp[0] = m_resp[0] | extra_resp[0];
  assign mem_resp[1] = m_resp[1] | extra_resp[1];

  orion_mem_arbiter #(.ARB_MODE(0), .CNTW(16)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .i_addr_i(i_addr[0]), .i_valid_i(i_valid[0]), .i_rdata_o(i_rdata[0]), .i_resp_o(i_resp[0]),
    .d_addr_i(d_addr[0]), .d_wdata_i(d_wdata[0]), .d_mask_i(d_mask[0]), .d_we_i(d_we[0]),
    .d_valid_i(d_valid[0]), .d_rdata_o(d_rdata[0]), .d_resp_o(d_resp[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_mask_o(mem_mask[0]),
    .mem_we_o(mem_we[0]), .mem_valid_o(mem_valid[0]), .mem_rdata_i(m_rdata[0]),
    .mem_resp_i(mem_resp[0]), .i_grants_o(i_grants0), .d_grants_o(d_grants0)
  );

  orion_mem_arbiter #(.ARB_MODE(1), .CNTW(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .i_addr_i(i_addr[1]), .i_valid_i(i_valid[1]), .i_rdata_o(i_rdata[1]), .i_resp_o(i_resp[1]),
    .d_addr_i(d_addr[1]), .d_wdata_i(d_wdata[1]), .d_mask_i(d_mask[1]), .d_we_i(d_we[1]),
    .d_valid_i(d_valid[1]), .d_rdata_o(d_rdata[1]), .d_resp_o(d_resp[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_mask_o(mem_mask[1]),
    .mem_we_o(mem_we[1]), .mem_valid_o(mem_valid[1]), .mem_rdata_i(m_rdata[1]),
    .mem_resp_i(mem_resp[1]), .i_grants_o(i_grants1), .d_grants_o(d_grants1)
  );

  function automatic logic [31:0] init_word(int n, int i);
    return {4'(n + 1), 4'h0, 8'(i), 8'(i ^ 8'h5A), 8'(~i)};
  endfunction

  // spram model: response two cycles after valid is first seen, shares the arbiter reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        m_resp[n]  <= 1'b0;
        m_cnt[n]   <= 0;
        m_rdata[n] <= '0;
        for (int i = 0; i < 256; i++) mem[n][i] <= init_word(n, i);
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (mem_valid[n] && !m_resp[n]) begin
          if (m_cnt[n] == 1) begin
            m_resp[n]  <= 1'b1;
            m_cnt[n]   <= 0;
            m_rdata[n] <= mem[n][mem_addr[n][9:2]];
            if (mem_we[n]) begin
              for (int b = 0; b < 4; b++)
                if (mem_mask[n][b]) mem[n][mem_addr[n][9:2]][8*b +: 8] <= mem_wdata[n][8*b +: 8];
            end
          end else begin
            m_cnt[n] <= m_cnt[n] + 1;
          end
        end else begin
          m_resp[n] <= 1'b0;
          m_cnt[n]  <= 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_ref();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 256; i++) ref_mem[n][i] = init_word(n, i);
  endtask

  task automatic push(int n, bit port, bit chk, logic [31:0] data);
    exp_t e;
    e.inst = n; e.port = port; e.chk = chk; e.data = data;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every response must match the front of the expected queue.
  task automatic sb_monitor();
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (i_resp[n] || d_resp[n]) begin
          checks++;
          act = d_resp[n] ? d_rdata[n] : i_rdata[n];
          if (i_resp[n] && d_resp[n]) begin
            errors++;
            $display("FAIL resp_both inst%0d: i_resp=1 d_resp=1, required only one", n);
          end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected inst%0d: port %0d responded, required none", n,
                     d_resp[n]);
          end else begin
            e = sb.pop_front();
            if (e.inst != n || e.port !== d_resp[n]) begin
              errors++;
              $display("FAIL resp_order: inst%0d port %0d responded, required inst%0d port %0d",
                       n, d_resp[n], e.inst, e.port);
            end else if (e.chk && act !== e.data) begin
              errors++;
              $display("FAIL rdata inst%0d port %0d: got %h, required %h", n, e.port, act,
                       e.data);
            end
          end
        end
      end
    end
  endtask

  // Waits at negedges for the given response; lat counts the negedges before it.
  task automatic wait_resp(int n, bit port, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (port ? d_resp[n] : i_resp[n]) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL resp_timeout inst%0d port %0d: no resp in 40 cycles, required one", n, port);
    end
  endtask

  task automatic test_reset();
    init_ref();
    i_addr[0] = 32'h40;
    i_valid[0] = 1'b1;
    d_valid[1] = 1'b1;
    repeat (2) step();
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (mem_valid[n] !== 1'b0 || mem_we[n] !== 1'b0 || i_resp[n] !== 1'b0 ||
          d_resp[n] !== 1'b0 || mem_addr[n] !== '0 || mem_wdata[n] !== '0 ||
          mem_mask[n] !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: valid=%b we=%b addr=%h wdata=%h mask=%h, required 0",
                 n, mem_valid[n], mem_we[n], mem_addr[n], mem_wdata[n], mem_mask[n]);
      end
    end
    checks++;
    if (i_grants0 !== 0 || d_grants0 !== 0 || i_grants1 !== 0 || d_grants1 !== 0) begin
      errors++;
      $display("FAIL reset_counters: %0d %0d %0d %0d, required all 0", i_grants0, d_grants0,
               i_grants1, d_grants1);
    end
    i_valid[0] = 1'b0;
    d_valid[1] = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_i_only();
    int lat;
    i_addr[0]  = 32'h40;
    i_valid[0] = 1'b1;
    push(0, 1'b0, 1'b1, ref_mem[0][16]);
    #1;
    checks++;
    if (mem_valid[0] !== 1'b1 || mem_addr[0] !== 32'h40 || mem_mask[0] !== 4'hF ||
        mem_we[0] !== 1'b0) begin
      errors++;
      $display("FAIL i_grant_same_cycle: valid=%b addr=%h mask=%h we=%b, required 1 40 f 0",
               mem_valid[0], mem_addr[0], mem_mask[0], mem_we[0]);
    end
    wait_resp(0, 1'b0, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL i_latency: got %0d cycles, required 2", lat);
    end
    step();
    i_valid[0] = 1'b0;
    checks++;
    if (i_grants0 !== 16'd1 || d_grants0 !== 16'd0) begin
      errors++;
      $display("FAIL i_only_counters: i=%0d d=%0d, required i=1 d=0", i_grants0, d_grants0);
    end
  endtask

  task automatic test_d_store();
    int          lat;
    logic [31:0] w;
    d_addr[0]  = 32'h100;
    d_wdata[0] = 32'hDEADBEEF;
    d_mask[0]  = 4'b0011;
    d_we[0]    = 1'b1;
    d_valid[0] = 1'b1;
    push(0, 1'b1, 1'b0, '0);
    #1;
    checks++;
    if (mem_valid[0] !== 1'b1 || mem_addr[0] !== 32'h100 || mem_wdata[0] !== 32'hDEADBEEF ||
        mem_mask[0] !== 4'b0011 || mem_we[0] !== 1'b1) begin
      errors++;
      $display("FAIL d_store_fields: addr=%h wdata=%h mask=%h we=%b, required 100 deadbeef 3 1",
               mem_addr[0], mem_wdata[0], mem_mask[0], mem_we[0]);
    end
    wait_resp(0, 1'b1, lat);
    step();
    d_valid[0] = 1'b0;
    d_we[0]    = 1'b0;
    w = init_word(0, 64);
    w[15:0] = 16'hBEEF;
    ref_mem[0][64] = w;
    i_addr[0]  = 32'h100;
    i_valid[0] = 1'b1;
    push(0, 1'b0, 1'b1, w);
    wait_resp(0, 1'b0, lat);
    step();
    i_valid[0] = 1'b0;
    checks++;
    if (d_grants0 !== 16'd1 || i_grants0 !== 16'd2) begin
      errors++;
      $display("FAIL d_store_counters: i=%0d d=%0d, required i=2 d=1", i_grants0, d_grants0);
    end
  endtask

  task automatic test_round_robin();
    int          lat, ni, nd, cyc;
    bit          done;
    logic [15:0] i0, d0;
    // A D access first so the next tie goes to I.
    d_addr[0]  = 32'h8;
    d_valid[0] = 1'b1;
    push(0, 1'b1, 1'b1, ref_mem[0][2]);
    wait_resp(0, 1'b1, lat);
    step();
    d_valid[0] = 1'b0;
    i0 = i_grants0;
    d0 = d_grants0;
    i_addr[0] = 32'h44;
    d_addr[0] = 32'h48;
    i_valid[0] = 1'b1;
    d_valid[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b0, 1'b1, ref_mem[0][17]);
      push(0, 1'b1, 1'b1, ref_mem[0][18]);
    end
    ni = 0; nd = 0; cyc = 0; done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cyc++;
      if (i_resp[0]) ni++;
      if (d_resp[0]) nd++;
      step();
      if (ni == 4) i_valid[0] = 1'b0;
      if (nd == 4) d_valid[0] = 1'b0;
      if (ni == 4 && nd == 4) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done || cyc != 24) begin
      errors++;
      $display("FAIL rr_back_to_back: done=%0d in %0d cycles, required done in 24", done, cyc);
    end
    checks++;
    if (i_grants0 - i0 !== 16'd4 || d_grants0 - d0 !== 16'd4) begin
      errors++;
      $display("FAIL rr_counters: di=%0d dd=%0d, required 4 and 4", i_grants0 - i0,
               d_grants0 - d0);
    end
  endtask

  task automatic test_fixed_priority();
    int lat, ni, nd;
    bit done;
    i_addr[1] = 32'h20;
    d_addr[1] = 32'h24;
    d_we[1]   = 1'b0;
    i_valid[1] = 1'b1;
    d_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) push(1, 1'b1, 1'b1, ref_mem[1][9]);
    push(1, 1'b0, 1'b1, ref_mem[1][8]);
    ni = 0; nd = 0; done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (d_resp[1]) nd++;
      if (i_resp[1]) ni++;
      step();
      if (nd == 4) begin
        d_valid[1] = 1'b0;
        done = 1'b1;
        break;
      end
    end
    #1;
    checks++;
    if (!done || ni != 0) begin
      errors++;
      $display("FAIL fixed_d_first: done=%0d i_resps=%0d, required done and 0", done, ni);
    end
    checks++;
    if (mem_valid[1] !== 1'b1 || mem_addr[1] !== 32'h20 || mem_we[1] !== 1'b0) begin
      errors++;
      $display("FAIL fixed_i_grant: valid=%b addr=%h we=%b, required 1 20 0", mem_valid[1],
               mem_addr[1], mem_we[1]);
    end
    wait_resp(1, 1'b0, lat);
    step();
    i_valid[1] = 1'b0;
    checks++;
    if (d_grants1 !== 2'd3 || i_grants1 !== 2'd1) begin
      errors++;
      $display("FAIL fixed_counters: d=%0d i=%0d, required d=3 i=1", d_grants1, i_grants1);
    end
  endtask

  task automatic test_contention();
    int lat;
    i_addr[0]  = 32'h80;
    i_valid[0] = 1'b1;
    push(0, 1'b0, 1'b1, ref_mem[0][32]);
    step();
    d_addr[0]  = 32'h84;
    d_we[0]    = 1'b0;
    d_valid[0] = 1'b1;
    push(0, 1'b1, 1'b1, ref_mem[0][33]);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (mem_valid[0] !== 1'b1 || mem_addr[0] !== 32'h80 || mem_mask[0] !== 4'hF ||
          mem_we[0] !== 1'b0) begin
        errors++;
        $display("FAIL busy_i_hold cycle %0d: addr=%h mask=%h we=%b, required 80 f 0", k,
                 mem_addr[0], mem_mask[0], mem_we[0]);
      end
      if (k == 0) step();
    end
    wait_resp(0, 1'b0, lat);
    step();
    i_valid[0] = 1'b0;
    #1;
    checks++;
    if (mem_valid[0] !== 1'b1 || mem_addr[0] !== 32'h84) begin
      errors++;
      $display("FAIL busy_d_next: valid=%b addr=%h, required 1 84", mem_valid[0], mem_addr[0]);
    end
    wait_resp(0, 1'b1, lat);
    step();
    d_valid[0] = 1'b0;
  endtask

  task automatic test_stray_resp();
    logic [15:0] i0, d0;
    i0 = i_grants0;
    d0 = d_grants0;
    extra_resp[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (i_resp[0] !== 1'b0 || d_resp[0] !== 1'b0) begin
      errors++;
      $display("FAIL stray_resp: i_resp=%b d_resp=%b, required 0 0", i_resp[0], d_resp[0]);
    end
    step();
    extra_resp[0] = 1'b0;
    step();
    checks++;
    if (i_grants0 !== i0 || d_grants0 !== d0 || mem_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL stray_counters: i=%0d d=%0d valid=%b, required %0d %0d 0", i_grants0,
               d_grants0, mem_valid[0], i0, d0);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    d_addr[0]  = 32'h10;
    d_we[0]    = 1'b0;
    d_valid[0] = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_valid[0] !== 1'b0 || mem_addr[0] !== '0 || mem_mask[0] !== '0 ||
        mem_we[0] !== 1'b0 || d_resp[0] !== 1'b0 || mem_wdata[0] !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: valid=%b addr=%h mask=%h resp=%b, required all 0",
               mem_valid[0], mem_addr[0], mem_mask[0], d_resp[0]);
    end
    checks++;
    if (i_grants0 !== 0 || d_grants0 !== 0 || i_grants1 !== 0 || d_grants1 !== 0) begin
      errors++;
      $display("FAIL async_reset_counters: %0d %0d %0d %0d, required all 0", i_grants0,
               d_grants0, i_grants1, d_grants1);
    end
    sb.delete();
    d_valid[0] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    init_ref();
    step();
    checks++;
    if (mem_valid[0] !== 1'b0 || d_grants0 !== 0 || i_grants0 !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%b i=%0d d=%0d, required 0 0 0", mem_valid[0],
               i_grants0, d_grants0);
    end
    for (int k = 0; k < 5; k++) begin
      i_addr[1]  = 32'(4 * k);
      i_valid[1] = 1'b1;
      push(1, 1'b0, 1'b1, ref_mem[1][k]);
      wait_resp(1, 1'b0, lat);
      step();
    end
    i_valid[1] = 1'b0;
    checks++;
    if (i_grants1 !== 2'd3 || d_grants1 !== 2'd0) begin
      errors++;
      $display("FAIL saturate: i=%0d d=%0d, required i=3 d=0", i_grants1, d_grants1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int n = 0; n < 2; n++) begin
      i_addr[n] = '0; d_addr[n] = '0; d_wdata[n] = '0; d_mask[n] = '0;
      d_we[n] = 1'b0; i_valid[n] = 1'b0; d_valid[n] = 1'b0; extra_resp[n] = 1'b0;
    end
    fork
      sb_monitor();
    join_none
    test_reset();
    test_i_only();
    test_d_store();
    test_round_robin();
    test_fixed_priority();
    test_contention();
    test_stray_resp();
    test_reset_mid();
    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
